fifo_stream_reader: RTL and testbench

Read-side drain engine for the core2 asynchronous FIFO. Sits in the `rdclk` domain and pulls words out through the FIFO's `rden`/`dataout`/`rdempty`/`rdusedw` read port. It hides the FIFO's one-cycle registered read latency and presents the words as a valid/ready stream with burst framing (`m_last`) to the downstream MAC datapath.

---
 rtl/lmac_fifo_pkg.sv | 12 +
 rtl/skid_buf2.sv | 54 +++++
 rtl/fifo_stream_reader.sv | 104 ++++++++++
 tb/tb_fifo_stream_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lmac_fifo_pkg.sv
// rtl/lmac_fifo_pkg.sv - shared state encodings and constants for the FIFO stream reader
package lmac_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry register FIFO holding {last, data} words for the output stream
module skid_buf2 #(
  parameter int DW = 9
) (
  input  logic          rdclk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ,
  output logic          valid
);

  logic [DW-1:0] ent0;
  logic [DW-1:0] ent1;
  logic          pop_ok;

  assign pop_ok = pop & (occ != 2'd0);
  assign dout   = ent0;
  assign valid  = (occ != 2'd0);

  // Head entry is always ent0; a pop shifts ent1 forward, a push fills the first free slot.
  always_ff @(posedge rdclk) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == 2'd0) ent0 <= din;
          else             ent1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains the async FIFO read port into a framed valid/ready stream
module fifo_stream_reader
  import lmac_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PTR   = 4,
  parameter int BURST = 4
) (
  input  logic                  rdclk,
  input  logic                  reset,
  output logic                  fifo_rden,
  input  logic [WIDTH-1:0]      fifo_dataout,
  input  logic                  fifo_rdempty,
  input  logic [PTR:0]          fifo_rdusedw,
  input  logic                  flush,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam logic [PTR:0] BURST_W = BURST[PTR:0];
  localparam logic [PTR:0] ONE_W   = {{PTR{1'b0}}, 1'b1};

  state_t       state;
  logic [PTR:0] remain;
  logic         inflight;
  logic         inflight_last;
  logic [1:0]   occ;
  logic         pop;
  logic [2:0]   credit;
  logic         issue_last;
  logic [WIDTH:0] buf_dout;

  // Credit counts buffer slots already promised: held words plus the word in flight, minus the one leaving now.
  assign pop        = m_valid & m_ready;
  assign credit     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rden  = (state == ST_BURST) && (remain != '0) && !fifo_rdempty && (credit <= 3'd1);
  assign issue_last = fifo_rden && (remain == ONE_W);
  assign busy       = (state != ST_IDLE);
  assign m_data     = buf_dout[WIDTH-1:0];
  assign m_last     = buf_dout[WIDTH];

  // Burst sequencing; the burst length is snapshotted in IDLE and only counts down afterwards.
  always_ff @(posedge rdclk) begin
    if (reset) begin
      state  <= ST_IDLE;
      remain <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_rdusedw >= BURST_W) begin
            remain <= BURST_W;
            state  <= ST_BURST;
          end else if (flush && (fifo_rdusedw != '0)) begin
            remain <= fifo_rdusedw;
            state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (fifo_rden) begin
            remain <= remain - ONE_W;
            if (issue_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && m_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Track the FIFO's one-cycle read latency so returning data is pushed with its last flag.
  always_ff @(posedge rdclk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= fifo_rden;
      inflight_last <= issue_last;
    end
  end

  // Count words accepted downstream; wraps naturally.
  always_ff @(posedge rdclk) begin
    if (reset) word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 16'd1;
  end

  skid_buf2 #(.DW(WIDTH + 1)) u_buf (
    .rdclk (rdclk),
    .reset (reset),
    .push  (inflight),
    .din   ({inflight_last, fifo_dataout}),
    .pop   (pop),
    .dout  (buf_dout),
    .occ   (occ),
    .valid (m_valid)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic        rdclk;
  logic        reset;
  logic        fifo_rden;
  logic [7:0]  fifo_dataout;
  logic        fifo_rdempty;
  logic [4:0]  fifo_rdusedw;
  logic        flush;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [15:0] word_cnt;

  logic        wrap_reset;
  logic        wrap_rden;
  logic [7:0]  wrap_dataout;
  logic        wrap_rdempty;
  logic [8:0]  wrap_rdusedw;
  logic        wrap_flush;
  logic [7:0]  wrap_data;
  logic        wrap_valid;
  logic        wrap_ready;
  logic        wrap_last;
  logic        wrap_busy;
  logic [15:0] wrap_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rden_n = 0;
  int first_valid = -1;
  int cnt2 = 0;
  int unstable;
  int t0;
  logic stall = 1'b0;
  logic [7:0] q[$];
  logic [8:0] acc_q[$];
  int rden_cyc[$];
  int acc_cyc[$];

  fifo_stream_reader #(.WIDTH(8), .PTR(4), .BURST(4)) dut (
    .rdclk(rdclk), .reset(reset), .fifo_rden(fifo_rden), .fifo_dataout(fifo_dataout),
    .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .word_cnt(word_cnt)
  );

  fifo_stream_reader #(.WIDTH(8), .PTR(8), .BURST(256)) dut_wrap (
    .rdclk(rdclk), .reset(wrap_reset), .fifo_rden(wrap_rden), .fifo_dataout(wrap_dataout),
    .fifo_rdempty(wrap_rdempty), .fifo_rdusedw(wrap_rdusedw), .flush(wrap_flush),
    .m_data(wrap_data), .m_valid(wrap_valid), .m_ready(wrap_ready), .m_last(wrap_last),
    .busy(wrap_busy), .word_cnt(wrap_cnt)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    fifo_rdempty = (q.size() == 0) || stall;
    fifo_rdusedw = 5'(q.size());
  endtask

  task automatic clr_log();
    rden_n = 0;
    first_valid = -1;
    rden_cyc.delete();
    acc_q.delete();
    acc_cyc.delete();
  endtask

  task automatic tick();
    logic s_rden;
    @(negedge rdclk);
    s_rden = fifo_rden;
    if (fifo_rden === 1'b1) begin
      rden_n++;
      rden_cyc.push_back(cyc);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      acc_q.push_back({m_last, m_data});
      acc_cyc.push_back(cyc);
    end
    if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (wrap_valid === 1'b1 && wrap_ready === 1'b1) begin
      if (cnt2 == 65537) wrap_ready = 1'b0;
      else cnt2++;
    end
    @(posedge rdclk);
    #1;
    cyc++;
    if (s_rden === 1'b1 && q.size() > 0) fifo_dataout = q.pop_front();
    upd();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [7:0] base, input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
    upd();
  endtask

  task automatic chk_words(input string tag, input logic [7:0] base, input int n);
    logic [8:0] e;
    chk({tag, "_count"}, acc_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < acc_q.size()) begin
        e = {(i == n - 1) ? 1'b1 : 1'b0, base + 8'(i)};
        chk($sformatf("%s_word%0d", tag, i), {23'd0, acc_q[i]}, {23'd0, e});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    m_ready = 1'b1;
    fifo_dataout = 8'h00;
    wrap_reset = 1'b1;
    wrap_dataout = 8'h5A;
    wrap_rdempty = 1'b0;
    wrap_rdusedw = 9'd256;
    wrap_flush = 1'b0;
    wrap_ready = 1'b1;
    q.delete();
    upd();

    // Reset state
    ticks(3);
    reset = 1'b0;
    chk("rst_rden", fifo_rden, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);

    // Threshold burst: 6 words held, 4 drained
    clr_log();
    load(8'h11, 6);
    t0 = cyc;
    ticks(15);
    chk("thr_rden_n", rden_n, 4);
    chk("thr_rden_first", (rden_cyc.size() > 0) ? rden_cyc[0] : -1, t0 + 1);
    chk("thr_rden_lastc", (rden_cyc.size() > 3) ? rden_cyc[3] : -1, t0 + 4);
    chk("thr_valid_lat", first_valid, t0 + 3);
    chk_words("thr", 8'h11, 4);
    chk("thr_acc_span", (acc_cyc.size() > 3) ? acc_cyc[3] - acc_cyc[0] : -1, 3);
    chk("thr_busy", busy, 0);
    chk("thr_cnt", word_cnt, 4);
    chk("thr_left", q.size(), 2);

    // Flush short burst: nothing without flush, then 2 words
    clr_log();
    load(8'hA0, 2);
    ticks(8);
    chk("nofl_rden_n", rden_n, 0);
    chk("nofl_busy", busy, 0);
    flush = 1'b1;
    ticks(12);
    flush = 1'b0;
    chk("fl_rden_n", rden_n, 2);
    chk_words("fl", 8'hA0, 2);
    chk("fl_cnt", word_cnt, 6);

    // Backpressure: only 2 reads while m_ready is low, head word stable
    clr_log();
    m_ready = 1'b0;
    load(8'h11, 4);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid === 1'b1 && m_data !== 8'h11) unstable++;
    end
    chk("bp_rden_n", rden_n, 2);
    chk("bp_rden_low", fifo_rden, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h11);
    chk("bp_stable", unstable, 0);
    chk("bp_busy", busy, 1);
    m_ready = 1'b1;
    ticks(12);
    chk("bp_rden_tot", rden_n, 4);
    chk_words("bp", 8'h11, 4);
    chk("bp_cnt", word_cnt, 10);
    chk("bp_idle", busy, 0);

    // Empty stall for 3 cycles after the 2nd read
    clr_log();
    load(8'h21, 4);
    for (int i = 0; i < 20 && rden_n < 2; i++) tick();
    chk("st_rden2", rden_n, 2);
    stall = 1'b1;
    upd();
    ticks(3);
    chk("st_paused", rden_n, 2);
    chk("st_busy", busy, 1);
    stall = 1'b0;
    upd();
    ticks(12);
    chk("st_rden_tot", rden_n, 4);
    chk_words("st", 8'h21, 4);
    chk("st_cnt", word_cnt, 14);

    // Reset asserted in the cycle of the 2nd read
    clr_log();
    load(8'h31, 4);
    for (int i = 0; i < 20 && rden_n < 1; i++) tick();
    reset = 1'b1;
    tick();
    q.delete();
    upd();
    reset = 1'b0;
    chk("mr_rden_in_rst", rden_n, 2);
    chk("mr_rden", fifo_rden, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_data", m_data, 0);
    chk("mr_last", m_last, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cnt", word_cnt, 0);
    clr_log();
    ticks(8);
    chk("mr_no_valid", first_valid, -1);
    chk("mr_no_rden", rden_n, 0);
    load(8'h41, 4);
    ticks(15);
    chk_words("mr_new", 8'h41, 4);
    chk("mr_new_cnt", word_cnt, 4);

    // Counter wrap: 65537 accepted words on a wide-burst instance
    wrap_reset = 1'b0;
    for (int i = 0; i < 80000 && cnt2 < 65537; i++) tick();
    ticks(3);
    chk("wrap_accepted", cnt2, 65537);
    chk("wrap_cnt", wrap_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
